// File: rtl/melody_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// melody_sequencer_if : control, pattern-write and oscillator-drive bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface melody_sequencer_if #(
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 4
);
  logic              i_start;
  logic              i_stop;
  logic              i_loop_en;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [11:0]       i_wr_data;
  logic [WIDTH-1:0]  o_tuning_increment;
  logic              o_gate;
  logic              o_playing;
  logic [ADDR_W-1:0] o_step_idx;
  logic              o_done;

  modport master (
    output i_start, i_stop, i_loop_en, i_wr_en, i_wr_addr, i_wr_data,
    input  o_tuning_increment, o_gate, o_playing, o_step_idx, o_done
  );

  modport slave (
    input  i_start, i_stop, i_loop_en, i_wr_en, i_wr_addr, i_wr_data,
    output o_tuning_increment, o_gate, o_playing, o_step_idx, o_done
  );
endinterface
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// melody_sequencer : 16-step note pattern player driving a square-wave
//                    oscillator half-period count and an articulation gate
// Revision 1.0
// ----------------------------------------------------------------------------
module melody_sequencer #(
  parameter int WIDTH      = 18,
  parameter int BEAT_DIV   = 3000000,
  parameter int GAP_CYCLES = 120000,
  parameter int STEPS      = 16,
  parameter int ADDR_W     = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  melody_sequencer_if.slave bus
);

  localparam int c_cnt_w = $clog2(15 * BEAT_DIV + 1);
  localparam logic [c_cnt_w-1:0] c_beat = c_cnt_w'(BEAT_DIV);
  localparam logic [c_cnt_w-1:0] c_gap  = c_cnt_w'(GAP_CYCLES);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
  localparam logic [ADDR_W-1:0]  c_last = ADDR_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_idx, w_idx_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_tuning, w_tuning_nxt;
  logic                 r_rest, w_rest_nxt;
  logic                 r_gate, w_gate_nxt;
  logic                 r_done, w_done_nxt;

  logic [11:0]          r_mem [STEPS];
  logic [11:0]          r_rd_data;

  logic [3:0]           w_dur;
  logic [2:0]           w_oct;
  logic [3:0]           w_semi;
  logic                 w_is_rest;
  logic [WIDTH-1:0]     w_base;
  logic [c_cnt_w-1:0]   w_len;

  assign w_dur     = r_rd_data[11:8];
  assign w_oct     = r_rd_data[7:5];
  assign w_semi    = r_rd_data[3:0];
  assign w_is_rest = r_rd_data[4] | (w_semi >= 4'd12);
  assign w_len     = c_beat * {{(c_cnt_w-4){1'b0}}, w_dur};

  // Octave-0 half-period counts, C2..B2, for a 12 MHz clock
  always_comb begin
    w_base = '0;
    case (w_semi)
      4'd0:    w_base = WIDTH'(91733);
      4'd1:    w_base = WIDTH'(86585);
      4'd2:    w_base = WIDTH'(81725);
      4'd3:    w_base = WIDTH'(77138);
      4'd4:    w_base = WIDTH'(72808);
      4'd5:    w_base = WIDTH'(68722);
      4'd6:    w_base = WIDTH'(64865);
      4'd7:    w_base = WIDTH'(61224);
      4'd8:    w_base = WIDTH'(57788);
      4'd9:    w_base = WIDTH'(54544);
      4'd10:   w_base = WIDTH'(51483);
      4'd11:   w_base = WIDTH'(48593);
      default: w_base = '0;
    endcase
  end

  // Read address follows the next step index so the word is ready during FETCH
  always_ff @(posedge clk) begin
    if (bus.i_wr_en) r_mem[bus.i_wr_addr] <= bus.i_wr_data;
    r_rd_data <= r_mem[w_idx_nxt];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_tuning_nxt = r_tuning;
    w_rest_nxt   = r_rest;
    w_done_nxt   = 1'b0;
    if (bus.i_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            w_state_nxt = S_FETCH;
            w_idx_nxt   = '0;
          end
        end
        S_FETCH: begin
          if (w_dur != 4'd0) begin
            w_state_nxt = S_PLAY;
            w_cnt_nxt   = w_len - c_one;
            w_rest_nxt  = w_is_rest;
            if (!w_is_rest) w_tuning_nxt = w_base >> w_oct;
          end else if ((r_idx != '0) && bus.i_loop_en) begin
            w_idx_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        S_PLAY: begin
          if (r_cnt == '0) begin
            if (r_idx == c_last) begin
              if (bus.i_loop_en) begin
                w_state_nxt = S_FETCH;
                w_idx_nxt   = '0;
              end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_state_nxt = S_FETCH;
              w_idx_nxt   = r_idx + ADDR_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt - c_one;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // Counter runs down to 0; the last GAP_CYCLES values mute the note
    w_gate_nxt = (w_state_nxt == S_PLAY) && !w_rest_nxt && (w_cnt_nxt >= c_gap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_tuning <= '0;
      r_rest   <= 1'b0;
      r_gate   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tuning <= w_tuning_nxt;
      r_rest   <= w_rest_nxt;
      r_gate   <= w_gate_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.o_tuning_increment = r_tuning;
  assign bus.o_gate             = r_gate;
  assign bus.o_playing          = (r_state != S_IDLE);
  assign bus.o_step_idx         = r_idx;
  assign bus.o_done             = r_done;

endmodule
`default_nettype wire
